// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port D-MEM arbiter: pipeline priority with aux starvation forcing
module dmem_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_req,
    input  logic             pipe_we,
    input  logic [DBITS-1:0] pipe_addr,
    input  logic [DBITS-1:0] pipe_wdata,
    output logic [DBITS-1:0] pipe_rdata,
    output logic             pipe_stall,
    input  logic             aux_req,
    input  logic             aux_we,
    input  logic [DBITS-1:0] aux_addr,
    input  logic [DBITS-1:0] aux_wdata,
    output logic             aux_gnt,
    output logic [DBITS-1:0] aux_rdata,
    output logic             aux_rvalid,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata
);

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        AUX_FORCE = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       force_aux;
    logic       pipe_sel;
    logic       aux_sel;

    // Grant decision: a forced aux request beats the pipe; otherwise the pipe wins.
    // Nothing is granted while reset is held so no write can slip out.
    always_comb begin
        force_aux = (state == AUX_FORCE) && aux_req;
        pipe_sel  = !reset && pipe_req && !force_aux;
        aux_sel   = !reset && aux_req && (force_aux || !pipe_req);
    end

    assign aux_gnt    = aux_sel;
    assign pipe_stall = !reset && force_aux && pipe_req;
    assign pipe_rdata = mem_rdata;

    // Memory port mux: the granted side drives the port; idle cycles park on the pipe with no write.
    always_comb begin
        mem_addr  = pipe_addr;
        mem_wdata = pipe_wdata;
        mem_we    = 1'b0;
        if (aux_sel) begin
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            mem_we    = aux_we;
        end else if (pipe_sel) begin
            mem_we    = pipe_we;
        end
    end

    // Arbitration state, starvation count and registered aux read return.
    // The force is armed when an aux request is denied again with the count
    // already saturated, so the forced grant lands STARVE_LIMIT+1 cycles after
    // the request rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PIPE_PRI;
            starve_cnt <= 4'd0;
            aux_rdata  <= '0;
            aux_rvalid <= 1'b0;
        end else begin
            aux_rvalid <= aux_sel && !aux_we;
            if (aux_sel && !aux_we) begin
                aux_rdata <= mem_rdata;
            end

            if (aux_req && !aux_sel) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end

            case (state)
                PIPE_PRI: begin
                    if (aux_req && !aux_sel && starve_cnt == LIMIT) begin
                        state <= AUX_FORCE;
                    end
                end
                AUX_FORCE: begin
                    if (aux_sel || !aux_req) begin
                        state <= PIPE_PRI;
                    end
                end
                default: state <= PIPE_PRI;
            endcase
        end
    end

endmodule
